// File: rtl/ram_master_if.sv
// Command and RAM-control signal bundle for ram_master. The shared data bus
// stays a plain inout on the master so tristate resolution remains a net.
interface ram_master_if;
  logic       req_in;
  logic       wr_in;
  logic [3:0] addr_in;
  logic [7:0] wdata_in;
  logic       ready_out;
  logic [7:0] rdata_out;
  logic       rvalid_out;
  logic       we_out;
  logic       enable_out;
  logic [3:0] addr_out;

  modport master (
    input  req_in, wr_in, addr_in, wdata_in,
    output ready_out, rdata_out, rvalid_out, we_out, enable_out, addr_out
  );

  modport slave (
    output req_in, wr_in, addr_in, wdata_in,
    input  ready_out, rdata_out, rvalid_out, we_out, enable_out, addr_out
  );
endinterface

// File: rtl/ram_master.sv
// Single-port RAM master: one command at a time, write in one cycle, read in
// two (READ + mandatory TURN cycle for bus turnaround).
module ram_master (
  input  logic          clock,
  input  logic          resetn,
  ram_master_if.master  bus,
  inout  wire  [7:0]    data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  state_t     state;
  logic [7:0] wdata_q;
  logic       drive;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      wdata_q        <= '0;
      drive          <= 1'b0;
      bus.we_out     <= 1'b0;
      bus.enable_out <= 1'b0;
      bus.addr_out   <= '0;
      bus.rdata_out  <= '0;
      bus.rvalid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_in) begin
            bus.addr_out <= bus.addr_in;
            wdata_q      <= bus.wdata_in;
            if (bus.wr_in) begin
              state      <= WRITE;
              bus.we_out <= 1'b1;
              drive      <= 1'b1;
            end else begin
              state          <= READ;
              bus.enable_out <= 1'b1;
            end
          end
        end
        WRITE: begin
          state      <= IDLE;
          bus.we_out <= 1'b0;
          drive      <= 1'b0;
        end
        READ: begin
          // RAM is driving the bus this cycle; capture on the exit edge
          state          <= TURN;
          bus.enable_out <= 1'b0;
          bus.rdata_out  <= data;
          bus.rvalid_out <= 1'b1;
        end
        TURN: begin
          state          <= IDLE;
          bus.rvalid_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated with resetn so the master never reports idle while held in reset
  assign bus.ready_out = resetn && (state == IDLE);
  assign data          = drive ? wdata_q : 8'hzz;

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 The module SHALL have these ports:
  clock        input   1  sole clock; all state updates on the rising edge
  resetn       input   1  asynchronous, active-low reset
  req_in       input   1  command request, sampled when ready_out=1
  wr_in        input   1  command type: 1=write, 0=read
  addr_in      input   4  command address
  wdata_in     input   8  write data
  ready_out    output  1  master idle, able to accept a command
  rdata_out    output  8  last read data
  rvalid_out   output  1  one-cycle pulse marking new rdata_out
  we_out       output  1  RAM write enable
  enable_out   output  1  RAM read enable
  addr_out     output  4  RAM address
  data         inout   8  shared bidirectional RAM data bus
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.

Function
REQ-003 The FSM SHALL have four states: IDLE, WRITE, READ, TURN.
REQ-004 ready_out SHALL be 1 only in IDLE.
REQ-005 In IDLE, req_in=1 SHALL latch wr_in, addr_in and wdata_in on the rising edge.
  - wr_in=1: next state WRITE
  - wr_in=0: next state READ
REQ-006 req_in while ready_out=0 SHALL be ignored; no command is queued.
REQ-007 WRITE state:
  - we_out=1, enable_out=0, addr_out = latched address
  - data driven with latched wdata for exactly this one cycle
  - next state IDLE
REQ-008 READ state:
  - we_out=0, enable_out=1, addr_out = latched address
  - data released to high-Z
  - rdata_out loaded from data on the edge that leaves READ
  - next state TURN
REQ-009 TURN state:
  - we_out=0, enable_out=0, data high-Z, addr_out held
  - rvalid_out=1 for this single cycle
  - next state IDLE
REQ-010 The data bus SHALL be driven only in WRITE and SHALL be high-Z in every other state and during reset, so master and RAM never contend.
REQ-011 we_out and enable_out SHALL never be 1 in the same cycle.
REQ-012 Latency, with acceptance at edge N:
  - write: WRITE is cycle N+1; ready_out=1 again in cycle N+2
  - read: READ is cycle N+1; rdata_out/rvalid_out are valid in cycle N+2; ready_out=1 in cycle N+3
REQ-013 Back-to-back operation:
  - write->write: one command every 2 cycles
  - read->any: one command every 3 cycles; the TURN cycle is mandatory bus turnaround
REQ-014 rdata_out SHALL hold its value until the next read completes; writes do not alter it.
REQ-015 Addresses 0..15 SHALL all be reachable; there is no address wrap or increment logic.
REQ-016 All outputs except data SHALL be registered or decoded from registered state only, with no combinational path from req_in to RAM-side pins.

Reset
REQ-017 resetn=0 SHALL immediately, without waiting for a clock edge, force:
  - state to IDLE
  - ready_out=0 while resetn=0
  - we_out=0, enable_out=0, addr_out=4'h0
  - rdata_out=8'h00, rvalid_out=0
  - data high-Z
REQ-018 ready_out SHALL be 1 in the first cycle after resetn deasserts.
REQ-019 Reset asserted during WRITE or READ SHALL abort the operation:
  - no rvalid_out pulse
  - rdata_out=8'h00
  - a write aborted before its WRITE cycle completes is not guaranteed to reach the RAM

Verification
REQ-020 The bench SHALL pair the master with the single-port RAM (write when we&&!enable; drive data when enable&&!we) and cover:
  - Reset: hold resetn=0 for 2 cycles -> all outputs at reset values, data=8'hzz, then ready_out=1.
  - Single write/read: write addr 4'h3 data 8'hA5, then read addr 4'h3 -> rvalid_out pulses once, 2 cycles after read acceptance, with rdata_out=8'hA5.
  - Full sweep: write addr i with data i+8'h10 for i=0..15, then read 15..0 -> each rdata_out = i+8'h10; we_out&&enable_out never 1; data never driven by the master in READ/TURN.
  - Busy request: pulse req_in while ready_out=0 (in READ) -> ignored, no extra RAM access, same rdata_out.
  - Back-to-back: write 4'h7=8'h3C immediately followed by read 4'h7 -> read accepted 2 cycles after the write; rdata_out=8'h3C; TURN cycle present.
  - Async reset mid-read: assert resetn between clock edges during READ -> enable_out drops at once, no rvalid_out pulse, rdata_out=8'h00.
